// File: rtl/sum_avg_decim.sv
// sum_avg_decim
// Averages 2^LOG2_N consecutive valid sums from an 8-input pipelined adder
// tree and queues the floor averages in a 2-entry output FIFO.
//
// Ports
//   clk        clock, all state updates on posedge
//   rst        synchronous active-high reset
//   in_valid   adder-tree inputs carry a valid sample set this cycle
//   sum        signed adder-tree output (LATENCY cycles after in_valid)
//   out_ready  consumer accepts out_data this cycle
//   out_valid  FIFO non-empty
//   out_data   signed average at the FIFO head
//   overflow   sticky: a result was dropped because the FIFO was full
//
// FIFO occupancy FSM
//   state | meaning
//   EMPTY | no results held, out_valid low
//   ONE   | one result held at mem[rd_ptr]
//   FULL  | two results held; a push without a pop is dropped
module sum_avg_decim #(
  parameter int SUM_W   = 15,
  parameter int LATENCY = 5,
  parameter int LOG2_N  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [SUM_W-1:0] sum,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [SUM_W-1:0] out_data,
  output logic                    overflow
);

  localparam int ACC_W = SUM_W + LOG2_N;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;

  logic [LATENCY-1:0]      vd;
  logic                    sv;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] frame_total;
  logic [LOG2_N-1:0]       cnt;
  logic                    frame_done;
  logic signed [SUM_W-1:0] result;

  logic signed [SUM_W-1:0] mem [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  occ_t                    state;
  occ_t                    state_next;
  logic                    push;
  logic                    pop;
  logic                    wr_en;
  logic                    drop;

  // The adder tree has no valid of its own; this delay line re-aligns
  // in_valid with the sum it produced.
  assign sv = vd[LATENCY-1];

  assign sum_ext     = ACC_W'(sum);
  assign frame_total = acc + sum_ext;
  assign frame_done  = sv && (cnt == {LOG2_N{1'b1}});
  // The sum of 2^LOG2_N SUM_W-bit values shifted back by LOG2_N always fits.
  assign result      = SUM_W'(frame_total >>> LOG2_N);

  always_ff @(posedge clk) begin
    if (rst) begin
      vd  <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      vd[0] <= in_valid;
      for (int k = 1; k < LATENCY; k++) begin
        vd[k] <= vd[k-1];
      end
      if (sv) begin
        acc <= (cnt == '0) ? sum_ext : frame_total;
        cnt <= cnt + LOG2_N'(1);
      end
    end
  end

  assign push      = frame_done;
  assign out_valid = (state != EMPTY);
  assign pop       = out_valid && out_ready;
  // A full FIFO can still accept when the head leaves in the same cycle.
  assign wr_en     = push && ((state != FULL) || pop);
  assign drop      = push && (state == FULL) && !pop;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (wr_en) begin
        mem[wr_ptr] <= result;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (push) state_next = ONE;
      ONE: begin
        if (push && !pop)      state_next = FULL;
        else if (pop && !push) state_next = EMPTY;
      end
      FULL:    if (pop && !push) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

endmodule
